// File: rtl/ir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_pkg
// Purpose  : Shared definitions for the IR command handler: NEC frame field
//            positions, the byte-inverse check constant and the layout of a
//            buffered command entry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ir_pkg;

  // Byte lanes of a decoded 32-bit NEC frame
  localparam int ADDR_LSB  = 0;
  localparam int ADDRN_LSB = 8;
  localparam int CMD_LSB   = 16;
  localparam int CMDN_LSB  = 24;

  // A byte and its transmitted complement XOR to all ones
  localparam logic [7:0] INV_CHECK = 8'hFF;

  localparam int ENTRY_W = 24;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  cmd;
  } cmd_entry_t;

  function automatic logic is_inverse(input logic [7:0] a, input logic [7:0] b);
    return (a ^ b) == INV_CHECK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ir_cmd_fifo
// Purpose  : Synchronous first-word-fall-through FIFO. The head entry is read
//            directly from storage and is valid whenever empty is low.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            push, push_data - write request and data
//            pop             - remove the head entry (ignored when empty)
//            head_data       - head entry (zero when empty)
//            full, empty     - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module ir_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A push into a full FIFO still succeeds when the head leaves in the same
  // cycle; a pop on an empty FIFO is ignored.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is never read while empty, so present zero rather than stale data
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ir_cmd_handler.sv
`default_nettype none
// ============================================================================
// Module   : ir_cmd_handler
// Purpose  : Integrity-checks decoded NEC frames, suppresses auto-repeat of a
//            held key and queues accepted commands for the system controller.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            frame_in, frame_valid   - decoded frame and its one-cycle strobe
//            cmd_addr, cmd_code      - head-of-queue command
//            cmd_valid, cmd_ready    - valid/ready handshake for the head
//            key_held                - same key repeating inside hold window
//            err_pulse, ovf_pulse    - integrity failure / dropped command
//            err_count               - saturating integrity failure count
// Revision : 1.0 - initial release
// ============================================================================
module ir_cmd_handler
  import ir_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_CHECK  = 1,
  parameter int HOLD_CYCLES = 12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] frame_in,
  input  logic        frame_valid,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_code,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        key_held,
  output logic        err_pulse,
  output logic        ovf_pulse,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  logic [7:0]    addr;
  logic [7:0]    addr_n;
  logic [7:0]    cmd;
  logic [7:0]    cmd_n;
  logic          frame_ok;
  logic          accept;
  logic          is_repeat;
  logic          push_new;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  cmd_entry_t    new_entry;
  cmd_entry_t    head_entry;
  cmd_entry_t    last_entry;
  logic          last_valid;
  logic [TW-1:0] timer;

  assign addr   = frame_in[ADDR_LSB  +: 8];
  assign addr_n = frame_in[ADDRN_LSB +: 8];
  assign cmd    = frame_in[CMD_LSB   +: 8];
  assign cmd_n  = frame_in[CMDN_LSB  +: 8];

  // With the address check disabled the second byte is the high half of an
  // extended 16-bit address rather than a complement.
  assign frame_ok = is_inverse(cmd, cmd_n) &&
                    ((ADDR_CHECK == 0) || is_inverse(addr, addr_n));

  always_comb begin
    new_entry.cmd  = cmd;
    new_entry.addr = (ADDR_CHECK != 0) ? {8'h00, addr} : {addr_n, addr};
  end

  assign accept    = frame_valid && !reset;
  assign is_repeat = (timer != '0) && last_valid && (last_entry == new_entry);
  assign push_new  = accept && frame_ok && !is_repeat;
  assign pop       = cmd_valid && cmd_ready;

  ir_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_new),
    .push_data (new_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_valid = !fifo_empty;
  assign cmd_addr  = head_entry.addr;
  assign cmd_code  = head_entry.cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= '0;
      last_valid <= 1'b0;
      last_entry <= '0;
      key_held   <= 1'b0;
      err_pulse  <= 1'b0;
      ovf_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      err_pulse <= accept && !frame_ok;
      // A simultaneous pop frees a slot, so only a push without pop overflows
      ovf_pulse <= push_new && fifo_full && !pop;

      if (accept && !frame_ok && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      // Any passing frame (new, repeat or dropped on overflow) restarts the
      // hold window and becomes the reference key.
      if (accept && frame_ok) begin
        timer      <= HOLD_LOAD;
        last_valid <= 1'b1;
        last_entry <= new_entry;
        key_held   <= is_repeat;
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
        if (timer == TIMER_ONE) begin
          last_valid <= 1'b0;
          key_held   <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ir_cmd_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_cmd_handler
// Purpose  : Self-checking bench for ir_cmd_handler (FIFO_DEPTH=4,
//            ADDR_CHECK=1, HOLD_CYCLES=100). Accepted commands are queued as
//            expectations and compared when the DUT hands them over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_cmd_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] frame_in;
  logic        frame_valid;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_code;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        key_held;
  logic        err_pulse;
  logic        ovf_pulse;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int exp_errs = 0;

  logic [23:0] sb [$];
  logic [23:0] exp_e;

  typedef struct {
    logic [31:0] frame;
    logic        bad;
    logic [23:0] entry;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  ir_cmd_handler #(
    .FIFO_DEPTH  (4),
    .ADDR_CHECK  (1),
    .HOLD_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .cmd_addr    (cmd_addr),
    .cmd_code    (cmd_code),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .key_held    (key_held),
    .err_pulse   (err_pulse),
    .ovf_pulse   (ovf_pulse),
    .err_count   (err_count)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Handshake monitor: an entry leaves at the next posedge
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h, required no entry", {cmd_addr, cmd_code});
      end else begin
        exp_e = sb.pop_front();
        check("pop_entry", {8'h00, cmd_addr, cmd_code}, {8'h00, exp_e});
      end
    end
  end

  task automatic send(input logic [31:0] f);
    @(posedge clk);
    #1 frame_in = f;
    frame_valid = 1'b1;
    @(posedge clk);
    #1 frame_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    cmd_ready = 1'b1;
    while ((sb.size() != 0 || cmd_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || cmd_valid) begin
      errors++;
      $display("FAIL drain: %0d entries pending, cmd_valid=%0b, required 0 and 0",
               sb.size(), cmd_valid);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hFE01FF00, 1'b0, 24'h000001};
    vecs[1] = '{32'hCD33AA55, 1'b1, 24'h000000};
    vecs[2] = '{32'h00FF00FF, 1'b0, 24'h00FFFF};
    vecs[3] = '{32'h0FF0A05F, 1'b0, 24'h005FF0};
    vecs[4] = '{32'h0FF0A05E, 1'b1, 24'h000000};
    vecs[5] = '{32'h7E81B44B, 1'b0, 24'h004B81};
    vecs[6] = '{32'h7E80B44B, 1'b1, 24'h000000};

    reset = 1'b1;
    frame_valid = 1'b0;
    frame_in = '0;
    cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_key_held", key_held, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_ovf_pulse", ovf_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_head", {cmd_addr, cmd_code}, 0);

    // First valid frame appears one cycle later
    sb.push_back(24'h005533);
    send(32'hCC33AA55);
    check("t1_cmd_valid", cmd_valid, 1);
    check("t1_cmd_addr", cmd_addr, 16'h0055);
    check("t1_cmd_code", cmd_code, 8'h33);
    check("t1_err_pulse", err_pulse, 0);
    drain();

    // Bad addr_n
    send(32'hCC33AA54);
    exp_errs++;
    check("t2_err_pulse", err_pulse, 1);
    check("t2_err_count", err_count, 1);
    check("t2_cmd_valid", cmd_valid, 0);
    @(posedge clk);
    #1 check("t2_err_pulse_one_cycle", err_pulse, 0);

    // Table of single frames, consumer always ready
    for (int i = 0; i < 7; i++) begin
      if (!vecs[i].bad) sb.push_back(vecs[i].entry);
      else exp_errs++;
      send(vecs[i].frame);
      check("tbl_err_pulse", err_pulse, vecs[i].bad);
      check("tbl_cmd_valid", cmd_valid, !vecs[i].bad);
      check("tbl_err_count", err_count, exp_errs);
      check("tbl_ovf_pulse", ovf_pulse, 0);
    end
    drain();

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      send(32'hCC33AA54);
      if (exp_errs < 255) exp_errs++;
      check("sat_err_count", err_count, exp_errs);
    end
    check("sat_final", err_count, 8'hFF);
    check("sat_cmd_valid", cmd_valid, 0);

    // Hold window: one entry for three frames 50 cycles apart
    sb.push_back(24'h005533);
    send(32'hCC33AA55);
    check("hold_first_valid", cmd_valid, 1);
    check("hold_first_key_held", key_held, 0);
    repeat (48) @(posedge clk);
    send(32'hCC33AA55);
    check("hold_second_key_held", key_held, 1);
    check("hold_second_no_push", cmd_valid, 0);
    repeat (48) @(posedge clk);
    send(32'hCC33AA55);
    check("hold_third_key_held", key_held, 1);
    check("hold_third_no_push", cmd_valid, 0);
    repeat (99) @(posedge clk);
    #1 check("hold_before_expiry", key_held, 1);
    @(posedge clk);
    #1 check("hold_after_expiry", key_held, 0);
    sb.push_back(24'h005533);
    send(32'hCC33AA55);
    check("hold_resend_push", cmd_valid, 1);
    check("hold_resend_key_held", key_held, 0);
    drain();

    // Overflow: four buffered, fifth dropped
    cmd_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) sb.push_back({16'h0010, 8'(c)});
      send(mk(8'h10, 8'(c)));
      check("ovf_pulse", ovf_pulse, (c == 5));
      check("ovf_err_pulse", err_pulse, 0);
    end
    check("ovf_head", cmd_code, 8'h01);

    // Full, push and pop in the same cycle
    sb.push_back(24'h001006);
    @(posedge clk);
    #1 frame_in = mk(8'h10, 8'h06);
    frame_valid = 1'b1;
    cmd_ready = 1'b1;
    @(posedge clk);
    #1 frame_valid = 1'b0;
    cmd_ready = 1'b0;
    check("fullpp_ovf_pulse", ovf_pulse, 0);
    check("fullpp_head", cmd_code, 8'h02);
    // Still full: another push without pop is dropped
    send(mk(8'h10, 8'h07));
    check("fullpp_still_full", ovf_pulse, 1);
    drain();

    // Reset mid-operation
    cmd_ready = 1'b0;
    sb.push_back(24'h00100A);
    send(mk(8'h10, 8'h0A));
    sb.push_back(24'h005533);
    send(32'hCC33AA55);
    send(32'hCC33AA55);
    check("rstmid_key_held_before", key_held, 1);
    check("rstmid_queued_before", cmd_valid, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    frame_valid = 1'b1;
    frame_in = 32'h7E81B44B;
    @(posedge clk);
    #1 reset = 1'b0;
    frame_valid = 1'b0;
    sb.delete();
    check("rstmid_cmd_valid", cmd_valid, 0);
    check("rstmid_key_held", key_held, 0);
    check("rstmid_err_count", err_count, 0);
    @(posedge clk);
    #1 check("rstmid_frame_ignored", cmd_valid, 0);
    sb.push_back(24'h005533);
    send(32'hCC33AA55);
    check("rstmid_new_valid", cmd_valid, 1);
    check("rstmid_new_code", cmd_code, 8'h33);
    check("rstmid_new_key_held", key_held, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
